mig_line_adapter: RTL and testbench

Parametrised cache-line adapter between the cache/arbiter request port and the MIG DDR2 user interface. Each accepted request moves one line of BEATS × APPDATA_WIDTH bits. A write is serialised into BEATS write-FIFO beats plus one address command. A read issues one address command and deserialises BEATS returned beats. Compared with the fixed two-beat controller it adds per-byte write masks, a ready/valid request handshake, a single-cycle completion response for both reads and writes, and a read timeout error.

---
 rtl/mig_if_pkg.sv | 29 ++
 rtl/line_beat_serdes.sv | 83 ++++++++
 rtl/mig_line_adapter.sv | 240 ++++++++++++++++++++++++
 tb/tb_mig_line_adapter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mig_if_pkg.sv
// Shared definitions for the MIG line adapter: FSM state codes, MIG
// command encodings and a counter-width helper that stays legal for
// single-entry ranges.
package mig_if_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_WR_DATA   = 3'd1;
    localparam state_t ST_WR_CMD    = 3'd2;
    localparam state_t ST_WR_SETTLE = 3'd3;
    localparam state_t ST_RD_CMD    = 3'd4;
    localparam state_t ST_RD_DATA   = 3'd5;
    localparam state_t ST_RSP       = 3'd6;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    // Bits needed to index n distinct values; never returns 0 so that a
    // one-beat line still gets a real (always-zero) index signal.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n > 32'd1) begin
            return $clog2(n);
        end else begin
            return 32'd1;
        end
    endfunction

endpackage

// File: rtl/line_beat_serdes.sv
// Line <-> beat conversion for the MIG adapter. The write side holds the
// accepted line and mask and presents the beat selected by beat_idx. The
// read side collects returned beats into slots; r_line_nxt already
// includes the beat being written this cycle so the caller can capture a
// complete line on the same edge as the last beat.
module line_beat_serdes
    import mig_if_pkg::*;
#(
    parameter int unsigned APPDATA_WIDTH = 128,
    parameter int unsigned BEATS         = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 w_load,
    input  logic [BEATS*APPDATA_WIDTH-1:0]       w_line,
    input  logic [BEATS*APPDATA_WIDTH/8-1:0]     w_mask,
    input  logic [cnt_width(BEATS)-1:0]          beat_idx,
    output logic [APPDATA_WIDTH-1:0]             w_beat,
    output logic [APPDATA_WIDTH/8-1:0]           w_beat_mask,
    input  logic                                 r_clr,
    input  logic                                 r_wr,
    input  logic [APPDATA_WIDTH-1:0]             r_beat,
    output logic [BEATS*APPDATA_WIDTH-1:0]       r_line_nxt
);

    localparam int unsigned LINE_W  = BEATS * APPDATA_WIDTH;
    localparam int unsigned MASK_W  = APPDATA_WIDTH / 8;
    localparam int unsigned LMASK_W = BEATS * MASK_W;

    logic [LINE_W-1:0]  line_r;
    logic [LMASK_W-1:0] mask_r;
    logic [LINE_W-1:0]  slots_r;
    logic [31:0]        data_base_s;
    logic [31:0]        mask_base_s;

    // Bit offsets of the currently indexed beat in the line and mask.
    always_comb begin
        data_base_s = 32'(beat_idx) * APPDATA_WIDTH;
        mask_base_s = 32'(beat_idx) * MASK_W;
    end

    // Write-side beat mux.
    always_comb begin
        w_beat      = line_r[data_base_s +: APPDATA_WIDTH];
        w_beat_mask = mask_r[mask_base_s +: MASK_W];
    end

    // Read-side slot update including the beat arriving this cycle.
    always_comb begin
        r_line_nxt = slots_r;
        if (r_wr) begin
            r_line_nxt[data_base_s +: APPDATA_WIDTH] = r_beat;
        end else begin
            r_line_nxt = slots_r;
        end
    end

    // Write line/mask holding registers, loaded on request acceptance.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_r <= {LINE_W{1'b0}};
            mask_r <= {LMASK_W{1'b0}};
        end else if (w_load) begin
            line_r <= w_line;
            mask_r <= w_mask;
        end else begin
            line_r <= line_r;
            mask_r <= mask_r;
        end
    end

    // Read slot file; cleared at read start so unfilled slots read as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slots_r <= {LINE_W{1'b0}};
        end else if (r_clr) begin
            slots_r <= {LINE_W{1'b0}};
        end else begin
            slots_r <= r_line_nxt;
        end
    end

endmodule

// File: rtl/mig_line_adapter.sv
// Cache-line adapter between a ready/valid request port and the MIG DDR2
// user interface. Writes stream BEATS masked beats into the write-data
// FIFO, issue one write command and wait a settle time; reads issue one
// command and gather BEATS beats, abandoning the read when the MIG goes
// quiet for too long. Every request finishes with a one-cycle response.
module mig_line_adapter
    import mig_if_pkg::*;
#(
    parameter int unsigned APPDATA_WIDTH = 128,
    parameter int unsigned BEATS         = 2,
    parameter int unsigned ADDR_WIDTH    = 31,
    parameter int unsigned WR_SETTLE     = 6,
    parameter int unsigned RD_TIMEOUT    = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_we,
    input  logic [ADDR_WIDTH-1:0]             req_addr,
    input  logic [BEATS*APPDATA_WIDTH-1:0]    req_wdata,
    input  logic [BEATS*APPDATA_WIDTH/8-1:0]  req_wmask,
    output logic                              rsp_valid,
    output logic                              rsp_err,
    output logic [BEATS*APPDATA_WIDTH-1:0]    rsp_rdata,
    input  logic                              app_af_afull,
    input  logic                              app_wdf_afull,
    input  logic                              rd_data_valid,
    input  logic [APPDATA_WIDTH-1:0]          rd_data_fifo_out,
    output logic                              app_af_wren,
    output logic [ADDR_WIDTH-1:0]             app_af_addr,
    output logic [2:0]                        app_af_cmd,
    output logic                              app_wdf_wren,
    output logic [APPDATA_WIDTH-1:0]          app_wdf_data,
    output logic [APPDATA_WIDTH/8-1:0]        app_wdf_mask_data
);

    localparam int unsigned LINE_W = BEATS * APPDATA_WIDTH;
    localparam int unsigned IDX_W  = cnt_width(BEATS);
    localparam int unsigned SET_W  = cnt_width(WR_SETTLE);
    localparam int unsigned TO_W   = cnt_width(RD_TIMEOUT + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(WR_SETTLE - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(RD_TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(RD_TIMEOUT);

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [IDX_W-1:0]        beat_r;
    logic [SET_W-1:0]        settle_r;
    logic [TO_W-1:0]         to_r;
    logic                    req_ready_r;
    logic [ADDR_WIDTH-1:0]   af_addr_r;
    logic [2:0]              af_cmd_r;
    logic                    rsp_valid_r;
    logic                    rsp_err_r;
    logic [LINE_W-1:0]       rsp_rdata_r;

    logic                    accept_s;
    logic                    last_beat_s;
    logic                    wdf_go_s;
    logic                    af_go_s;
    logic                    rd_beat_s;
    logic                    timeout_s;
    logic [LINE_W-1:0]       rd_line_nxt_s;

    // Handshake and per-cycle event decode.
    always_comb begin
        accept_s    = req_valid & req_ready_r;
        last_beat_s = (beat_r == LAST_IDX);
        wdf_go_s    = (state_r == ST_WR_DATA) & ~app_wdf_afull;
        af_go_s     = ((state_r == ST_WR_CMD) | (state_r == ST_RD_CMD)) & ~app_af_afull;
        rd_beat_s   = (state_r == ST_RD_DATA) & rd_data_valid;
        timeout_s   = (state_r == ST_RD_DATA) & ~rd_data_valid & (to_r == TO_LAST);
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = req_we ? ST_WR_DATA : ST_RD_CMD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (wdf_go_s && last_beat_s) begin
                    state_nxt_s = ST_WR_CMD;
                end else begin
                    state_nxt_s = ST_WR_DATA;
                end
            end
            ST_WR_CMD: begin
                if (af_go_s) begin
                    state_nxt_s = ST_WR_SETTLE;
                end else begin
                    state_nxt_s = ST_WR_CMD;
                end
            end
            ST_WR_SETTLE: begin
                if (settle_r == SET_LAST) begin
                    state_nxt_s = ST_RSP;
                end else begin
                    state_nxt_s = ST_WR_SETTLE;
                end
            end
            ST_RD_CMD: begin
                if (af_go_s) begin
                    state_nxt_s = ST_RD_DATA;
                end else begin
                    state_nxt_s = ST_RD_CMD;
                end
            end
            ST_RD_DATA: begin
                if ((rd_beat_s && last_beat_s) || timeout_s) begin
                    state_nxt_s = ST_RSP;
                end else begin
                    state_nxt_s = ST_RD_DATA;
                end
            end
            ST_RSP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register and ready flag (ready stays low while reset is held).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            req_ready_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            req_ready_r <= (state_nxt_s == ST_IDLE);
        end
    end

    // Beat index shared by the write mux and the read slot writer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_r <= {IDX_W{1'b0}};
        end else if (accept_s) begin
            beat_r <= {IDX_W{1'b0}};
        end else if ((wdf_go_s || rd_beat_s) && !last_beat_s) begin
            beat_r <= beat_r + IDX_W'(1);
        end else begin
            beat_r <= beat_r;
        end
    end

    // Write settle counter; runs only while in the settle state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            settle_r <= {SET_W{1'b0}};
        end else if (state_r == ST_WR_SETTLE) begin
            settle_r <= settle_r + SET_W'(1);
        end else begin
            settle_r <= {SET_W{1'b0}};
        end
    end

    // Read idle-gap counter; restarts on every beat and saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_r <= {TO_W{1'b0}};
        end else if ((state_r != ST_RD_DATA) || rd_data_valid) begin
            to_r <= {TO_W{1'b0}};
        end else if (to_r != TO_MAX) begin
            to_r <= to_r + TO_W'(1);
        end else begin
            to_r <= to_r;
        end
    end

    // Command address/opcode, loaded at acceptance and held until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            af_addr_r <= {ADDR_WIDTH{1'b0}};
            af_cmd_r  <= 3'b000;
        end else if (accept_s) begin
            af_addr_r <= req_addr;
            af_cmd_r  <= req_we ? CMD_WR : CMD_RD;
        end else begin
            af_addr_r <= af_addr_r;
            af_cmd_r  <= af_cmd_r;
        end
    end

    // Completion response; read data is captured together with the last beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= {LINE_W{1'b0}};
        end else begin
            rsp_valid_r <= (state_nxt_s == ST_RSP);
            rsp_err_r   <= timeout_s;
            if ((state_r == ST_RD_DATA) && (state_nxt_s == ST_RSP)) begin
                rsp_rdata_r <= rd_line_nxt_s;
            end else begin
                rsp_rdata_r <= rsp_rdata_r;
            end
        end
    end

    line_beat_serdes #(
        .APPDATA_WIDTH (APPDATA_WIDTH),
        .BEATS         (BEATS)
    ) u_serdes (
        .clk         (clk),
        .rst         (rst),
        .w_load      (accept_s),
        .w_line      (req_wdata),
        .w_mask      (req_wmask),
        .beat_idx    (beat_r),
        .w_beat      (app_wdf_data),
        .w_beat_mask (app_wdf_mask_data),
        .r_clr       (accept_s & ~req_we),
        .r_wr        (rd_beat_s),
        .r_beat      (rd_data_fifo_out),
        .r_line_nxt  (rd_line_nxt_s)
    );

    // FIFO enables are gated by almost-full in the same cycle.
    assign app_wdf_wren = wdf_go_s;
    assign app_af_wren  = af_go_s;
    assign app_af_addr  = af_addr_r;
    assign app_af_cmd   = af_cmd_r;
    assign req_ready    = req_ready_r;
    assign rsp_valid    = rsp_valid_r;
    assign rsp_err      = rsp_err_r;
    assign rsp_rdata    = rsp_rdata_r;

endmodule

// File: tb/tb_mig_line_adapter.sv
// Directed bench for mig_line_adapter (BEATS=2, 128-bit beats,
// WR_SETTLE=6, RD_TIMEOUT=8). Inputs change 1 ns after the rising edge and
// outputs are sampled 1 ns later, well before the next edge.
module tb_mig_line_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [30:0]  req_addr;
    logic [255:0] req_wdata;
    logic [31:0]  req_wmask;
    logic         rsp_valid;
    logic         rsp_err;
    logic [255:0] rsp_rdata;
    logic         app_af_afull;
    logic         app_wdf_afull;
    logic         rd_data_valid;
    logic [127:0] rd_data_fifo_out;
    logic         app_af_wren;
    logic [30:0]  app_af_addr;
    logic [2:0]   app_af_cmd;
    logic         app_wdf_wren;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask_data;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int cyc      = 0;
    int t0       = 0;

    mig_line_adapter #(
        .APPDATA_WIDTH (128),
        .BEATS         (2),
        .ADDR_WIDTH    (31),
        .WR_SETTLE     (6),
        .RD_TIMEOUT    (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_we            (req_we),
        .req_addr          (req_addr),
        .req_wdata         (req_wdata),
        .req_wmask         (req_wmask),
        .rsp_valid         (rsp_valid),
        .rsp_err           (rsp_err),
        .rsp_rdata         (rsp_rdata),
        .app_af_afull      (app_af_afull),
        .app_wdf_afull     (app_wdf_afull),
        .rd_data_valid     (rd_data_valid),
        .rd_data_fifo_out  (rd_data_fifo_out),
        .app_af_wren       (app_af_wren),
        .app_af_addr       (app_af_addr),
        .app_af_cmd        (app_af_cmd),
        .app_wdf_wren      (app_wdf_wren),
        .app_wdf_data      (app_wdf_data),
        .app_wdf_mask_data (app_wdf_mask_data)
    );

    always #5 clk = ~clk;

    // Cycle number used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 20) begin
            next_cycle();
            n++;
        end
        chk({tag, "_ready"}, req_ready, 1'b1);
    endtask

    // Waits for rsp_valid; lat is cycles since t0, or -1 if it never came.
    task automatic wait_rsp(output int lat);
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            next_cycle();
            if (rsp_valid) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {req_ready, rsp_valid, rsp_err, app_af_wren, app_wdf_wren,
                            app_af_cmd, app_af_addr}, 256'd0);
        chk({tag, "_rdata"}, rsp_rdata, 256'd0);
        chk({tag, "_wdf"}, {app_wdf_data, app_wdf_mask_data}, 256'd0);
    endtask

    // Unobstructed write: beats in T+1, T+2, command in T+3, response in T+10.
    task automatic do_write(input string tag, input logic [30:0] addr,
                            input logic [255:0] data, input logic [31:0] mask);
        int lat;
        wait_ready(tag);
        req_valid = 1'b1; req_we = 1'b1; req_addr = addr;
        req_wdata = data; req_wmask = mask;
        t0 = cyc;
        next_cycle();
        req_valid = 1'b0;
        chk({tag, "_b0_wren"}, app_wdf_wren, 1'b1);
        chk({tag, "_b0_data"}, app_wdf_data, data[127:0]);
        chk({tag, "_b0_mask"}, app_wdf_mask_data, mask[15:0]);
        next_cycle();
        chk({tag, "_b1_wren"}, app_wdf_wren, 1'b1);
        chk({tag, "_b1_data"}, app_wdf_data, data[255:128]);
        chk({tag, "_b1_mask"}, app_wdf_mask_data, mask[31:16]);
        next_cycle();
        chk({tag, "_cmd"}, {app_af_wren, app_wdf_wren, app_af_cmd, app_af_addr},
            {1'b1, 1'b0, 3'b000, addr});
        wait_rsp(lat);
        chk({tag, "_rsp_lat"}, lat, 10);
        chk({tag, "_rsp_err"}, rsp_err, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] a0, b0, x0, y0, x1, z1, x2, y2;
        logic [255:0] exp_line;
        int lat;
        int seen;

        a0 = {4{32'hA0A0_0001}};
        b0 = {4{32'hB0B0_0002}};
        x0 = {4{32'h1234_5678}};
        y0 = {4{32'h9ABC_DEF0}};
        x1 = {4{32'hC001_D00D}};
        z1 = {4{32'hDEAD_BEEF}};
        x2 = {4{32'h0F0F_0F0F}};
        y2 = {4{32'h7070_7070}};

        rst = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = 31'd0;
        req_wdata = 256'd0; req_wmask = 32'd0;
        app_af_afull = 1'b0; app_wdf_afull = 1'b0;
        rd_data_valid = 1'b0; rd_data_fifo_out = 128'd0;
        #2;
        check_all_zero("reset");
        next_cycle();
        next_cycle();
        rst = 1'b1;

        // Plain two-beat write.
        do_write("wr1", 31'h100, {b0, a0}, 32'h0000_0000);

        // Write with the data FIFO almost full for three cycles after beat 0.
        wait_ready("wr2");
        req_valid = 1'b1; req_we = 1'b1; req_addr = 31'h140;
        req_wdata = {y0, x0}; req_wmask = {16'hFFFF, 16'h00F0};
        t0 = cyc;
        next_cycle();
        req_valid = 1'b0;
        chk("wr2_b0_wren", app_wdf_wren, 1'b1);
        chk("wr2_b0_mask", app_wdf_mask_data, 16'h00F0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            app_wdf_afull = 1'b1;
            #1;
            chk("wr2_hold_wren", app_wdf_wren, 1'b0);
            chk("wr2_hold_data", {app_wdf_data, app_wdf_mask_data}, {y0, 16'hFFFF});
        end
        next_cycle();
        app_wdf_afull = 1'b0;
        #1;
        chk("wr2_b1_wren", app_wdf_wren, 1'b1);
        chk("wr2_b1_data", app_wdf_data, y0);
        chk("wr2_b1_mask", app_wdf_mask_data, 16'hFFFF);
        next_cycle();
        chk("wr2_no_dup", {app_wdf_wren, app_af_wren}, 2'b01);
        wait_rsp(lat);
        chk("wr2_rsp_lat", lat, 13);

        // Read: beat X in T+2, beat Y five cycles later.
        wait_ready("rd1");
        req_valid = 1'b1; req_we = 1'b0; req_addr = 31'h2A0;
        t0 = cyc;
        next_cycle();
        req_valid = 1'b0;
        chk("rd1_cmd", {app_af_wren, app_af_cmd, app_af_addr}, {1'b1, 3'b001, 31'h2A0});
        next_cycle();
        rd_data_valid = 1'b1; rd_data_fifo_out = x0;
        #1;
        chk("rd1_cmd_single", app_af_wren, 1'b0);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            rd_data_valid = 1'b0;
        end
        next_cycle();
        rd_data_valid = 1'b1; rd_data_fifo_out = y0;
        next_cycle();
        rd_data_valid = 1'b0;
        #1;
        chk("rd1_rsp", {rsp_valid, rsp_err}, 2'b10);
        chk("rd1_lat", cyc - t0, 8);
        chk("rd1_rdata", rsp_rdata, {y0, x0});
        next_cycle();
        chk("rd1_pulse", rsp_valid, 1'b0);
        chk("rd1_hold", rsp_rdata, {y0, x0});

        // Read timeout: one beat, then silence; a late beat must be ignored.
        wait_ready("rd2");
        req_valid = 1'b1; req_we = 1'b0; req_addr = 31'h3C0;
        t0 = cyc;
        next_cycle();
        req_valid = 1'b0;
        chk("rd2_cmd", {app_af_wren, app_af_cmd}, {1'b1, 3'b001});
        next_cycle();
        rd_data_valid = 1'b1; rd_data_fifo_out = x1;
        next_cycle();
        rd_data_valid = 1'b0;
        wait_rsp(lat);
        chk("rd2_lat", lat, 11);
        chk("rd2_err", rsp_err, 1'b1);
        exp_line = {128'd0, x1};
        chk("rd2_rdata", rsp_rdata, exp_line);
        next_cycle();
        rd_data_valid = 1'b1; rd_data_fifo_out = z1;
        next_cycle();
        rd_data_valid = 1'b0;
        #1;
        chk("rd2_late", {rsp_valid, rsp_rdata}, {1'b0, exp_line});

        // Address FIFO almost full for four cycles; request held throughout.
        wait_ready("rd3");
        req_valid = 1'b1; req_we = 1'b0; req_addr = 31'h1F0;
        t0 = cyc;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            app_af_afull = 1'b1;
            #1;
            chk("rd3_af_stall", {app_af_wren, req_ready}, 2'b00);
        end
        next_cycle();
        app_af_afull = 1'b0;
        #1;
        chk("rd3_af_go", {app_af_wren, req_ready, app_af_cmd, app_af_addr},
            {1'b1, 1'b0, 3'b001, 31'h1F0});
        next_cycle();
        rd_data_valid = 1'b1; rd_data_fifo_out = x2;
        #1;
        chk("rd3_af_single", {app_af_wren, req_ready}, 2'b00);
        next_cycle();
        rd_data_fifo_out = y2;
        #1;
        chk("rd3_busy", req_ready, 1'b0);
        next_cycle();
        rd_data_valid = 1'b0;
        #1;
        chk("rd3_rsp", {rsp_valid, rsp_err, req_ready}, 3'b100);
        chk("rd3_lat", cyc - t0, 8);
        chk("rd3_rdata", rsp_rdata, {y2, x2});
        next_cycle();
        req_valid = 1'b0;
        chk("rd3_idle_ready", req_ready, 1'b1);

        // Reset during the write burst, then a normal write.
        wait_ready("wr3");
        req_valid = 1'b1; req_we = 1'b1; req_addr = 31'h5A0;
        req_wdata = {a0, b0}; req_wmask = 32'h0000_0000;
        next_cycle();
        req_valid = 1'b0;
        chk("wr3_in_burst", app_wdf_wren, 1'b1);
        rst = 1'b0;
        #1;
        check_all_zero("wr3_rst");
        next_cycle();
        next_cycle();
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            next_cycle();
            if (rsp_valid || app_af_wren || app_wdf_wren) seen++;
        end
        chk("wr3_abandoned", seen, 0);
        do_write("wr4", 31'h600, {x1, z1}, 32'h00FF_FF00);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
